divisor_control: RTL and testbench
==================================

DIVISOR_CONTROL -- requirements
Module: divisor_control

Interface
REQ-001 Parameter: tamanyo, 16, operand/result width in bits (two's complement).
REQ-002 Parameter: TIMEOUT, 64, max cycles to wait for Div_Done before declaring error; SHALL be >= tamanyo+4.
REQ-003 Port: CLK  in  1  single clock; all state updates on rising edge.
REQ-004 Port: RSTa  in  1  asynchronous, active-low reset.
REQ-005 Port: In_Valid  in  1  upstream offers an operand pair.
REQ-006 Port: In_Ready  out  1  block accepts the pair this cycle.
REQ-007 Port: In_Num, In_Den  in  tamanyo each  signed dividend/divisor.
REQ-008 Port: Div_Start  out  1  start request to the algorithmic divider.
REQ-009 Port: Div_Num, Div_Den  out  tamanyo each  operands driven to the divider.
REQ-010 Port: Div_Done  in  1  divider result-ready level.
REQ-011 Port: Div_Coc, Div_Res  in  tamanyo each  divider quotient/remainder.
REQ-012 Port: Out_Valid  out  1  result available downstream.
REQ-013 Port: Out_Ready  in  1  downstream accepts the result.
REQ-014 Port: Out_Coc, Out_Res  out  tamanyo each  registered quotient/remainder.
REQ-015 Port: Out_DivZero, Out_Timeout  out  1 each  error flags, qualified by Out_Valid.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, OUTPUT.
REQ-017 In IDLE, In_Ready SHALL be 1 iff Div_Done==0; all other states: In_Ready=0.
REQ-018 Handshake In_Valid&In_Ready SHALL register In_Num/In_Den into Div_Num/Div_Den; these SHALL remain stable until the next accepted pair.
REQ-019 On accept with In_Den!=0: next state LAUNCH, timeout counter cleared.
REQ-020 On accept with In_Den==0: divider not started; next state OUTPUT with Out_Coc=0, Out_Res=In_Num, Out_DivZero=1, Out_Timeout=0.
REQ-021 Div_Start SHALL be 1 exactly while state==LAUNCH (registered output, first high the cycle after accept).
REQ-022 In LAUNCH, the first edge sampling Div_Done=1 SHALL capture Div_Coc/Div_Res into Out_Coc/Out_Res, clear both flags, go to OUTPUT; Div_Start falls the same edge.
REQ-023 In LAUNCH, the counter increments each cycle; when it reaches TIMEOUT with Div_Done still 0: Out_Coc=0, Out_Res=0, Out_Timeout=1, go to OUTPUT.
REQ-024 Out_Valid SHALL be 1 exactly while state==OUTPUT; Out_Coc/Out_Res/flags SHALL hold stable while Out_Valid=1 and Out_Ready=0.
REQ-025 OUTPUT with Out_Ready=1: transfer completes that edge, next state IDLE.
REQ-026 Out_Ready is ignored outside OUTPUT; In_Valid is ignored outside IDLE.
REQ-027 Results pass through unmodified (divider sign convention preserved); no arithmetic in this block other than the zero compare.
REQ-028 Latency accept->Out_Valid: 1 cycle for divide-by-zero; otherwise Div_Done response cycles +2.
REQ-029 Throughput: one operation in flight; a new accept requires prior result transfer and Div_Done low.

Reset
REQ-030 RSTa=0 SHALL immediately force state IDLE, Div_Start=0, Out_Valid=0, Div_Num=Div_Den=0, Out_Coc=Out_Res=0, both flags 0, counter 0.
REQ-031 Reset asserted mid-LAUNCH or mid-OUTPUT SHALL abandon the operation without emitting a result; after release, the block waits for Div_Done=0 before accepting.

Verification
REQ-032 Num=15, Den=3, divider model returns 5/0 -> Div_Start held until Done, Out_Coc=5, Out_Res=0, flags 0, one Out_Valid transfer.
REQ-033 Num=-17, Den=3, model returns -5/-2, Out_Ready held low 10 cycles -> Out_Valid and outputs stable throughout, transfer on first Out_Ready=1.
REQ-034 Num=-23, Den=0 -> no Div_Start pulse, Out_Valid the next cycle, Out_Coc=0, Out_Res=-23, Out_DivZero=1.
REQ-035 Num=17, Den=-3, model never asserts Done -> Out_Timeout=1 after TIMEOUT cycles, Out_Coc=Out_Res=0, Div_Start deasserted.
REQ-036 Div_Done left high after a result -> In_Ready stays 0 until Done drops; back-to-back pairs (15/3, 17/3) produce results in order.
REQ-037 RSTa pulsed low mid-LAUNCH -> all outputs at reset values asynchronously, no result emitted, next pair 18/-3 processed normally.

Source files
------------

// File: rtl/divisor_control.sv
// Control wrapper around an algorithmic signed divider: input/output valid-ready
// handshakes, divide-by-zero bypass and a watchdog on the divider's Div_Done.
module divisor_control #(
    parameter int tamanyo = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [tamanyo-1:0] In_Num,
    input  logic [tamanyo-1:0] In_Den,
    output logic               Div_Start,
    output logic [tamanyo-1:0] Div_Num,
    output logic [tamanyo-1:0] Div_Den,
    input  logic               Div_Done,
    input  logic [tamanyo-1:0] Div_Coc,
    input  logic [tamanyo-1:0] Div_Res,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [tamanyo-1:0] Out_Coc,
    output logic [tamanyo-1:0] Out_Res,
    output logic               Out_DivZero,
    output logic               Out_Timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] OUTPUT = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // A divider still holding Done from the previous operation blocks new accepts.
    assign In_Ready = (state == IDLE) && !Div_Done;

    // Div_Start and Out_Valid are dedicated flops kept in lockstep with the state
    // so they are glitch-free registered outputs.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state       <= IDLE;
            cnt         <= '0;
            Div_Start   <= 1'b0;
            Out_Valid   <= 1'b0;
            Div_Num     <= '0;
            Div_Den     <= '0;
            Out_Coc     <= '0;
            Out_Res     <= '0;
            Out_DivZero <= 1'b0;
            Out_Timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (In_Valid && In_Ready) begin
                        Div_Num <= In_Num;
                        Div_Den <= In_Den;
                        cnt     <= '0;
                        if (In_Den != '0) begin
                            state     <= LAUNCH;
                            Div_Start <= 1'b1;
                        end else begin
                            state       <= OUTPUT;
                            Out_Valid   <= 1'b1;
                            Out_Coc     <= '0;
                            Out_Res     <= In_Num;
                            Out_DivZero <= 1'b1;
                            Out_Timeout <= 1'b0;
                        end
                    end
                end
                LAUNCH: begin
                    if (Div_Done) begin
                        state       <= OUTPUT;
                        Div_Start   <= 1'b0;
                        Out_Valid   <= 1'b1;
                        Out_Coc     <= Div_Coc;
                        Out_Res     <= Div_Res;
                        Out_DivZero <= 1'b0;
                        Out_Timeout <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(TIMEOUT - 1)) begin
                            state       <= OUTPUT;
                            Div_Start   <= 1'b0;
                            Out_Valid   <= 1'b1;
                            Out_Coc     <= '0;
                            Out_Res     <= '0;
                            Out_DivZero <= 1'b0;
                            Out_Timeout <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (Out_Ready) begin
                        state     <= IDLE;
                        Out_Valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    Div_Start <= 1'b0;
                    Out_Valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_control.sv
// Self-checking bench for divisor_control: a behavioural divider, a scoreboard
// monitor, table-driven directed cases, reset corner cases and random operations.
module tb_divisor_control;

    localparam int W  = 16;
    localparam int TO = 64;

    logic         CLK, RSTa;
    logic         In_Valid, In_Ready;
    logic [W-1:0] In_Num, In_Den;
    logic         Div_Start, Div_Done;
    logic [W-1:0] Div_Num, Div_Den, Div_Coc, Div_Res;
    logic         Out_Valid, Out_Ready;
    logic [W-1:0] Out_Coc, Out_Res;
    logic         Out_DivZero, Out_Timeout;

    divisor_control #(.tamanyo(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RSTa(RSTa),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Num(In_Num), .In_Den(In_Den),
        .Div_Start(Div_Start), .Div_Num(Div_Num), .Div_Den(Div_Den),
        .Div_Done(Div_Done), .Div_Coc(Div_Coc), .Div_Res(Div_Res),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Coc(Out_Coc), .Out_Res(Out_Res),
        .Out_DivZero(Out_DivZero), .Out_Timeout(Out_Timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural divider: answers dv_dly cycles into Div_Start, holds Done dv_hold extra cycles.
    int dv_dly = 0, dv_hold = 0, dcnt = 0, hold_left = 0;
    bit dv_never = 1'b0;

    initial begin
        logic signed [W-1:0] sn, sd;
        Div_Done = 1'b0; Div_Coc = '0; Div_Res = '0;
        forever begin
            @(negedge CLK);
            if (Div_Start) begin
                if (!dv_never && !Div_Done) begin
                    if (dcnt >= dv_dly) begin
                        sn = Div_Num; sd = Div_Den;
                        Div_Coc = sn / sd;
                        Div_Res = sn % sd;
                        Div_Done = 1'b1;
                        hold_left = dv_hold;
                    end else dcnt++;
                end
            end else begin
                dcnt = 0;
                if (Div_Done) begin
                    if (hold_left == 0) Div_Done = 1'b0;
                    else hold_left--;
                end
            end
        end
    end

    // Scoreboard: expected results derived from the accepted operands.
    typedef struct {
        logic [W-1:0] coc, res;
        logic         dz, to;
        int           lat;
    } exp_t;

    exp_t         q[$];
    bit           op_dz = 1'b0, dz_next = 1'b0, prev_hold = 1'b0;
    int           stcount = 0;
    logic [W-1:0] p_coc, p_res;
    logic         p_dz, p_to;

    initial begin
        exp_t e;
        logic signed [W-1:0] sn, sd;
        forever begin
            @(negedge CLK);
            #3;
            if (RSTa) begin
                if (dz_next) begin
                    check("dz_latency_valid", 32'(Out_Valid), 32'd1);
                    dz_next = 1'b0;
                end
                if (In_Valid && In_Ready) begin
                    sn = In_Num; sd = In_Den;
                    if (sd == 0) begin
                        e.coc = '0; e.res = In_Num; e.dz = 1'b1; e.to = 1'b0;
                    end else if (dv_never) begin
                        e.coc = '0; e.res = '0; e.dz = 1'b0; e.to = 1'b1;
                    end else begin
                        e.coc = sn / sd; e.res = sn % sd; e.dz = 1'b0; e.to = 1'b0;
                    end
                    e.lat = dv_dly + 1;
                    q.push_back(e);
                    op_dz   = (sd == 0);
                    dz_next = (sd == 0);
                    stcount = 0;
                end
                if (Div_Start) stcount++;
                if (op_dz) check("dz_no_start", 32'(Div_Start), 32'd0);
                if (prev_hold) begin
                    check("hold_valid", 32'(Out_Valid), 32'd1);
                    check("hold_coc", 32'(Out_Coc), 32'(p_coc));
                    check("hold_res", 32'(Out_Res), 32'(p_res));
                    check("hold_flags", {30'd0, Out_DivZero, Out_Timeout}, {30'd0, p_dz, p_to});
                end
                if (Out_Valid && Out_Ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_result", 32'(Out_Valid), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("sb_coc", 32'(Out_Coc), 32'(e.coc));
                        check("sb_res", 32'(Out_Res), 32'(e.res));
                        check("sb_divzero", 32'(Out_DivZero), 32'(e.dz));
                        check("sb_timeout", 32'(Out_Timeout), 32'(e.to));
                        if (e.to) check("timeout_cycles", 32'(stcount), 32'(TO));
                        else if (!e.dz) check("start_cycles", 32'(stcount), 32'(e.lat));
                    end
                    op_dz = 1'b0;
                end
                prev_hold = Out_Valid && !Out_Ready;
                p_coc = Out_Coc; p_res = Out_Res; p_dz = Out_DivZero; p_to = Out_Timeout;
                if (Div_Done) check("ready_blocked_by_done", 32'(In_Ready), 32'd0);
            end
        end
    end

    // One operation: offer the pair, wait for the result, stall rwait cycles, transfer.
    task automatic do_op(input logic [W-1:0] num, input logic [W-1:0] den, input int dly,
                         input bit never, input int hold, input int rwait, input bit junk,
                         input bit chk, input logic [W-1:0] xcoc, input logic [W-1:0] xres,
                         input logic xdz, input logic xto);
        bit got;
        @(negedge CLK);
        dv_dly = dly; dv_never = never; dv_hold = hold;
        Out_Ready = (rwait == 0);
        In_Valid = 1'b1; In_Num = num; In_Den = den;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            #3;
            if (In_Ready) got = 1'b1;
            @(negedge CLK);
        end
        if (!got) begin
            check("accept_timeout", 32'(got), 32'd1);
            In_Valid = 1'b0;
            return;
        end
        if (junk) begin
            In_Num = W'($urandom); In_Den = W'($urandom);
        end else In_Valid = 1'b0;
        for (int k = 0; k < TO + 40 && !Out_Valid; k++) begin
            @(negedge CLK);
            if (junk) begin
                In_Num = W'($urandom); In_Den = W'($urandom);
            end
        end
        In_Valid = 1'b0;
        if (!Out_Valid) begin
            check("result_timeout", 32'(Out_Valid), 32'd1);
            return;
        end
        repeat (rwait) @(negedge CLK);
        Out_Ready = 1'b1;
        #3;
        if (chk) begin
            check("vec_coc", 32'(Out_Coc), 32'(xcoc));
            check("vec_res", 32'(Out_Res), 32'(xres));
            check("vec_flags", {30'd0, Out_DivZero, Out_Timeout}, {30'd0, xdz, xto});
            check("vec_start_low", 32'(Div_Start), 32'd0);
        end
        @(negedge CLK);
        Out_Ready = 1'b0;
        #1;
        check("single_transfer", 32'(Out_Valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, 32'(Div_Start), 32'd0);
        check({tag, "_valid"}, 32'(Out_Valid), 32'd0);
        check({tag, "_divnum"}, 32'(Div_Num), 32'd0);
        check({tag, "_divden"}, 32'(Div_Den), 32'd0);
        check({tag, "_coc"}, 32'(Out_Coc), 32'd0);
        check({tag, "_res"}, 32'(Out_Res), 32'd0);
        check({tag, "_flags"}, {30'd0, Out_DivZero, Out_Timeout}, 32'd0);
    endtask

    typedef struct {
        logic [W-1:0] num, den;
        int           dly;
        bit           never;
        int           hold, rwait;
        logic [W-1:0] coc, res;
        logic         dz, to;
    } vec_t;

    function automatic vec_t mk(input int num, input int den, input int dly, input bit never,
                                input int hold, input int rwait, input int coc, input int res,
                                input bit dz, input bit to);
        vec_t v;
        v.num = W'(num); v.den = W'(den); v.dly = dly; v.never = never;
        v.hold = hold; v.rwait = rwait; v.coc = W'(coc); v.res = W'(res);
        v.dz = dz; v.to = to;
        return v;
    endfunction

    vec_t tbl[7];

    initial begin
        #1_000_000;
        n_cmp++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        logic [W-1:0] rn, rd;
        tbl[0] = mk( 15,  3, 3, 1'b0, 0,  0,  5,   0, 1'b0, 1'b0);
        tbl[1] = mk(-17,  3, 1, 1'b0, 0, 10, -5,  -2, 1'b0, 1'b0);
        tbl[2] = mk(-23,  0, 0, 1'b0, 0,  1,  0, -23, 1'b1, 1'b0);
        tbl[3] = mk( 17, -3, 0, 1'b1, 0,  2,  0,   0, 1'b0, 1'b1);
        tbl[4] = mk( 15,  3, 0, 1'b0, 4,  0,  5,   0, 1'b0, 1'b0);
        tbl[5] = mk( 17,  3, 2, 1'b0, 0,  0,  5,   2, 1'b0, 1'b0);
        tbl[6] = mk(-32768, 7, 5, 1'b0, 1, 3, -4681, -1, 1'b0, 1'b0);

        RSTa = 1'b0; In_Valid = 1'b0; In_Num = '0; In_Den = '0; Out_Ready = 1'b0;
        #2;
        check_reset_outputs("por");
        repeat (2) @(negedge CLK);
        RSTa = 1'b1;

        for (int unsigned i = 0; i < 7; i++)
            do_op(tbl[i].num, tbl[i].den, tbl[i].dly, tbl[i].never, tbl[i].hold,
                  tbl[i].rwait, 1'b0, 1'b1, tbl[i].coc, tbl[i].res, tbl[i].dz, tbl[i].to);

        // Reset in the middle of a launched division abandons it.
        @(negedge CLK);
        dv_never = 1'b1; dv_hold = 0;
        In_Valid = 1'b1; In_Num = W'(17); In_Den = W'(3);
        @(negedge CLK);
        In_Valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("pre_reset_start", 32'(Div_Start), 32'd1);
        @(posedge CLK);
        #1;
        RSTa = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        q.delete(); op_dz = 1'b0; dz_next = 1'b0; prev_hold = 1'b0; stcount = 0;
        @(negedge CLK);
        RSTa = 1'b1;
        dv_never = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            #1;
            check("post_reset_no_valid", 32'(Out_Valid), 32'd0);
        end
        do_op(W'(18), W'(-3), 2, 1'b0, 0, 1, 1'b0, 1'b1, W'(-6), W'(0), 1'b0, 1'b0);

        // Random operations, checked by the scoreboard.
        for (int i = 0; i < 60; i++) begin
            rn = W'($urandom);
            case ($urandom_range(0, 5))
                0: rd = '0;
                1, 2: rd = W'(int'($urandom_range(0, 14)) - 7);
                default: rd = W'($urandom);
            endcase
            if (rn == 16'h8000 && rd == 16'hffff) rd = W'(1);
            do_op(rn, rd, int'($urandom_range(0, 6)), ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), 1'b0, '0, '0, 1'b0, 1'b0);
        end

        repeat (8) @(negedge CLK);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
